lsu_load_store: RTL and testbench
=================================

# lsu_load_store

Load/store unit that performs RV32I data-memory accesses over a ready/valid bus and produces the aligned, sign/zero-extended load value. That value drives the `wr_data` input of the write-back data mux and is selected there with `sel = 2'b00`. While an access is in flight the unit asserts `stall` to freeze the PC and the register-file write.

## Interface
- `TIMEOUT`, default 255: bus-wait cycles before `bus_err` is raised; 0 disables the timeout.
- `clk  in  1`: single clock; all state changes on the rising edge.
- `rst_n  in  1`: reset, asynchronous, active-low.
- `start  in  1`: current instruction is a load or store; sampled in IDLE only.
- `is_store  in  1`: 1 for a store, 0 for a load.
- `funct3  in  3`: RV32I size/sign field.
- `addr  in  32`: byte address (rs1 + imm).
- `rs2_data  in  32`: store source data.
- `mem_req  out  1`: bus request.
- `mem_we  out  1`: write enable.
- `mem_be  out  4`: byte enables.
- `mem_addr  out  32`: word address, `{addr[31:2],2'b00}`.
- `mem_wdata  out  32`: lane-replicated store data.
- `mem_ready  in  1`: bus completes the transfer on the edge where it is sampled high with `mem_req`.
- `mem_rdata  in  32`: read data, valid with `mem_ready`.
- `stall  out  1`: hold the pipeline.
- `done  out  1`: one-cycle pulse when the access completes.
- `wr_data  out  32`: extended load result, fed to the write-back mux.
- `misalign  out  1`: one-cycle pulse for a misaligned or illegal access.
- `bus_err  out  1`: one-cycle pulse when the bus times out.

## Operation
- States: IDLE, REQ, DONE.
- **IDLE** with `start=1`:
  - Legal and aligned -> latch `addr`, `funct3`, `is_store` and the formatted store data; go to REQ.
  - Misaligned or illegal -> `misalign=1` for the next cycle; stay in IDLE; no bus access.
- Legal `funct3`:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other value is illegal.
- Alignment rules:
  - Half-word access with `addr[0]=1` is misaligned.
  - Word access with `addr[1:0]!=0` is misaligned.
- Store formatting:
  - SB: `be = 4'b0001 << addr[1:0]`, `wdata = {4{rs2[7:0]}}`.
  - SH: `be = 4'b0011 << addr[1:0]`, `wdata = {2{rs2[15:0]}}`.
  - SW: `be = 4'b1111`, `wdata = rs2`.
- Load byte enables: always `4'b1111`.
- **REQ**:
  - `mem_req=1`; `mem_we`, `mem_be`, `mem_addr`, `mem_wdata` come from latched values and are held stable until the transfer completes.
  - On `mem_ready=1`: for a load, capture `mem_rdata >> (8*addr[1:0])`, extend it per `funct3` (sign for LB/LH, zero for LBU/LHU, none for LW) into `wr_data`; then go to DONE.
  - Wait counter (8+ bits, sized for `TIMEOUT`) increments every REQ cycle without `mem_ready`.
  - Counter reaching `TIMEOUT` (when `TIMEOUT != 0`) -> drop `mem_req`, pulse `bus_err`, go to IDLE; `wr_data` is unchanged.
- **DONE**: `done=1`, `stall=0`; go to IDLE unconditionally. `start` in DONE is ignored, because the same instruction is still presented.
- `stall = (IDLE & start & legal & aligned) | REQ`. `stall` is combinational from state and inputs.
- `wr_data` holds its value until the next completed load; stores never change it.
- `start` while in REQ has no effect.

## Timing
- Reset (asynchronous, immediate): state IDLE; `mem_req`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`, `done`, `misalign`, `bus_err`, `wr_data`, wait counter all 0.
- Reset asserted while in REQ drops `mem_req` in the same instant; the bus must discard the transfer.
- Latency, counted from the `start` cycle (c0) with zero-wait memory:
  - c1: REQ with `mem_ready=1`.
  - c2: DONE, `done=1`, `wr_data` valid.
  - c3: IDLE.
- Each memory wait cycle adds one cycle to the latency.
- Misalign: `start` in c0 -> `misalign=1` in c1; `stall` stays 0 throughout.
- Timeout: `mem_req` is high for exactly `TIMEOUT` cycles, then `bus_err=1` for one cycle together with `mem_req=0`.
- `mem_ready` while `mem_req=0` is ignored.
- `mem_rdata` is sampled only in the REQ cycle where `mem_ready=1`.

## Test plan
- **LW, no wait:** `start`, `addr=0x100`, `funct3=010`, `mem_rdata=0xDEADBEEF`, ready in first REQ cycle.
  - Required: `mem_addr=0x100`, `be=1111`, `done` at c2, `wr_data=0xDEADBEEF`, `stall` high in c0–c1 only.
- **LB vs LBU, 3 wait cycles:** `addr=0x103`, `mem_rdata=0x80123456`.
  - Required: LB gives `wr_data=0xFFFFFF80`; LBU gives `0x00000080`; `done` at c5.
- **SH to upper half:** `addr=0x202`, `rs2=0x0000ABCD`.
  - Required: `mem_addr=0x200`, `be=1100`, `wdata=0xABCDABCD`, `we=1`, `wr_data` unchanged.
- **Misaligned and illegal accesses:** LW at `addr=0x101`, then `funct3=011`.
  - Required: `misalign` pulse at c1 each time, `mem_req` never rises, `stall=0`.
- **Timeout:** `TIMEOUT=4`, `mem_ready` held at 0.
  - Required: `mem_req` high for 4 cycles, then `bus_err` pulses once and the unit returns to IDLE.
  - Required: a following LW with ready completes normally.
- **Reset mid-access:** `rst_n=0` during REQ.
  - Required: `mem_req=0` immediately, all outputs 0.
  - Required: after release, no `done` without a new `start`.

Source files
------------

// File: rtl/lsu_load_store.sv
// RV32I load/store unit: drives one ready/valid data-memory transfer per access
// and returns the aligned, sign/zero-extended load value for write-back.
module lsu_load_store #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] rs2_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] wr_data,
  output logic        misalign,
  output logic        bus_err
);

  localparam int unsigned CW    = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam bit          TO_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [1:0]    lat_off;
  logic [2:0]    lat_f3;

  logic        legal;
  logic        aligned;
  logic [3:0]  be_fmt;
  logic [31:0] wdata_fmt;
  logic [31:0] rdata_shift;
  logic [31:0] load_val;

  // Decode legality and natural alignment of the presented access
  always_comb begin
    legal   = 1'b0;
    aligned = 1'b1;
    if (is_store) legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    else          legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                          (funct3 == 3'b100) || (funct3 == 3'b101);
    case (funct3[1:0])
      2'b01:   aligned = ~addr[0];
      2'b10:   aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  // Store lane replication and byte enables; loads always read the full word
  always_comb begin
    be_fmt    = 4'b1111;
    wdata_fmt = rs2_data;
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          be_fmt    = 4'b0001 << addr[1:0];
          wdata_fmt = {4{rs2_data[7:0]}};
        end
        2'b01: begin
          be_fmt    = 4'b0011 << addr[1:0];
          wdata_fmt = {2{rs2_data[15:0]}};
        end
        default: begin
          be_fmt    = 4'b1111;
          wdata_fmt = rs2_data;
        end
      endcase
    end
  end

  // Align the returned word to the latched byte offset and extend it
  always_comb begin
    rdata_shift = mem_rdata >> {lat_off, 3'b000};
    case (lat_f3)
      3'b000:  load_val = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
      3'b001:  load_val = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
      3'b100:  load_val = {24'h0, rdata_shift[7:0]};
      3'b101:  load_val = {16'h0, rdata_shift[15:0]};
      default: load_val = rdata_shift;
    endcase
  end

  assign stall = (state == REQ) | ((state == IDLE) & start & legal & aligned);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      lat_off   <= 2'b00;
      lat_f3    <= 3'b000;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'b0000;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      done      <= 1'b0;
      misalign  <= 1'b0;
      bus_err   <= 1'b0;
      wr_data   <= 32'h0;
    end else begin
      done     <= 1'b0;
      misalign <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (legal && aligned) begin
              state     <= REQ;
              wait_cnt  <= '0;
              lat_off   <= addr[1:0];
              lat_f3    <= funct3;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_be    <= be_fmt;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_wdata <= wdata_fmt;
            end else begin
              misalign <= 1'b1;
            end
          end
        end
        REQ: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
            if (!mem_we) wr_data <= load_val;
          end else if (TO_EN && ((wait_cnt + CW'(1)) == CW'(TIMEOUT))) begin
            mem_req <= 1'b0;
            bus_err <= 1'b1;
            state   <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_load_store.sv
// Bench for lsu_load_store: directed test-plan cases plus randomized accesses
// checked against a byte-lane reference model.
module tb_lsu_load_store;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] rs2_data = 32'h0;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        stall;
  logic        done;
  logic [31:0] wr_data;
  logic        misalign;
  logic        bus_err;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_wr = 32'h0;

  lsu_load_store #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .rs2_data(rs2_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .stall(stall), .done(done),
    .wr_data(wr_data), .misalign(misalign), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: access sizes in bytes, lanes computed arithmetically
  function automatic bit m_legal(input bit st, input logic [2:0] f3);
    if (st) return f3 < 3'd3;
    return (f3 < 3'd3) || (f3 == 3'd4) || (f3 == 3'd5);
  endfunction

  function automatic int unsigned m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [3:0] m_be(input bit st, input logic [2:0] f3, input logic [31:0] a);
    logic [3:0]  be;
    int unsigned off;
    int unsigned nb;
    if (!st) return 4'hF;
    off = a % 4;
    nb  = m_size(f3);
    for (int unsigned i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + nb);
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    int unsigned nb;
    nb = m_size(f3);
    for (int unsigned i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % nb) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rd);
    longint v;
    longint span;
    int unsigned nb;
    nb   = m_size(f3);
    v    = longint'(rd) >> (8 * (a % 4));
    if (nb == 4) return 32'(v);
    span = longint'(1) << (8 * nb);
    v    = v % span;
    if (!f3[2] && (v >= span / 2)) v = v - span;
    return 32'(v);
  endfunction

  // One complete access starting at posedge+1 of cycle c0
  task automatic access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] rd, input int waits,
                        input string tag);
    bit ok;
    ok = m_legal(st, f3) && ((a % m_size(f3)) == 0);
    start = 1'b1; is_store = st; funct3 = f3; addr = a; rs2_data = d; mem_ready = 1'b0;
    #1;
    chk({tag, "_stall_c0"}, 32'(stall), 32'(ok));
    step();
    start = 1'b0;
    if (!ok) begin
      chk({tag, "_misalign"}, 32'(misalign), 32'd1);
      chk({tag, "_noreq"}, 32'(mem_req), 32'd0);
      chk({tag, "_nostall"}, 32'(stall), 32'd0);
      step();
      chk({tag, "_misalign_end"}, 32'(misalign), 32'd0);
      chk({tag, "_noreq2"}, 32'(mem_req), 32'd0);
      return;
    end
    chk({tag, "_nomisalign"}, 32'(misalign), 32'd0);
    for (int k = 0; k <= waits; k++) begin
      chk({tag, "_req"}, 32'(mem_req), 32'd1);
      chk({tag, "_stall"}, 32'(stall), 32'd1);
      chk({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
      chk({tag, "_we"}, 32'(mem_we), 32'(st));
      chk({tag, "_be"}, 32'(mem_be), 32'(m_be(st, f3, a)));
      if (st) chk({tag, "_wdata"}, mem_wdata, m_wdata(f3, d));
      chk({tag, "_nodone"}, 32'(done), 32'd0);
      start = 1'($urandom); is_store = 1'($urandom); funct3 = 3'($urandom);
      addr = $urandom; rs2_data = $urandom;
      mem_ready = (k == waits);
      mem_rdata = (k == waits) ? rd : $urandom;
      step();
    end
    if (!st) m_wr = m_load(f3, a, rd);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_stall_done"}, 32'(stall), 32'd0);
    chk({tag, "_req_done"}, 32'(mem_req), 32'd0);
    chk({tag, "_wr_data"}, wr_data, m_wr);
    chk({tag, "_buserr"}, 32'(bus_err), 32'd0);
    start = 1'b1; mem_ready = 1'b1; mem_rdata = $urandom;
    step();
    start = 1'b0; mem_ready = 1'b0;
    chk({tag, "_done_end"}, 32'(done), 32'd0);
    chk({tag, "_idle_noreq"}, 32'(mem_req), 32'd0);
  endtask

  initial begin
    logic [2:0]  f3_tab [7];
    logic [2:0]  rf3;
    logic [31:0] a;
    bit          rst_st;

    f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};
    #1 rst_n = 1'b0;
    #1;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_be", 32'(mem_be), 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wr_data", wr_data, 32'h0);
    chk("rst_flags", {29'h0, done, misalign, bus_err}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();

    access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, "lw");
    chk("lw_value", wr_data, 32'hDEADBEEF);
    access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80123456, 3, "lb");
    chk("lb_value", wr_data, 32'hFFFFFF80);
    access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80123456, 3, "lbu");
    chk("lbu_value", wr_data, 32'h00000080);
    access(1'b1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 0, "sh");
    chk("sh_be", 32'(mem_be), 32'h0000000C);
    chk("sh_wdata", mem_wdata, 32'hABCDABCD);
    chk("sh_keep", wr_data, 32'h00000080);
    access(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, "lw_mis");
    access(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, "ill");

    // Bus never answers: request held TO cycles, then one error pulse
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h300; mem_ready = 1'b0;
    step();
    start = 1'b0;
    for (int k = 0; k < int'(TO); k++) begin
      chk("to_req", 32'(mem_req), 32'd1);
      chk("to_noerr", 32'(bus_err), 32'd0);
      step();
    end
    chk("to_buserr", 32'(bus_err), 32'd1);
    chk("to_req_drop", 32'(mem_req), 32'd0);
    chk("to_nodone", 32'(done), 32'd0);
    chk("to_stall", 32'(stall), 32'd0);
    chk("to_keep", wr_data, m_wr);
    step();
    chk("to_buserr_end", 32'(bus_err), 32'd0);
    access(1'b0, 3'b010, 32'h304, 32'h0, 32'h13579BDF, 1, "lw_after_to");

    for (int n = 0; n < 60; n++) begin
      rf3 = f3_tab[$urandom_range(0, 6)];
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~((32'(m_size(rf3)) - 32'd1) & 32'h3);
      access(1'($urandom), rf3, a, $urandom, $urandom, $urandom_range(0, 3), "rnd");
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        mem_ready = 1'($urandom);
        step();
        chk("gap_noreq", 32'(mem_req), 32'd0);
        chk("gap_nodone", 32'(done), 32'd0);
      end
      mem_ready = 1'b0;
    end

    // Reset while the transfer is outstanding
    rst_st = 1'($urandom);
    start = 1'b1; is_store = rst_st; funct3 = 3'b010; addr = 32'h400; rs2_data = $urandom;
    step();
    start = 1'b0;
    step();
    chk("mid_req", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    m_wr = 32'h0;
    chk("mid_req_drop", 32'(mem_req), 32'd0);
    chk("mid_we", 32'(mem_we), 32'd0);
    chk("mid_be", 32'(mem_be), 32'd0);
    chk("mid_addr", mem_addr, 32'h0);
    chk("mid_wdata", mem_wdata, 32'h0);
    chk("mid_wr_data", wr_data, m_wr);
    chk("mid_flags", {28'h0, stall, done, misalign, bus_err}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mem_ready = 1'b1;
      step();
      chk("post_rst_nodone", 32'(done), 32'd0);
      chk("post_rst_noreq", 32'(mem_req), 32'd0);
    end
    mem_ready = 1'b0;
    access(1'b0, 3'b101, 32'h502, 32'h0, 32'h8001FFFF, 2, "lhu_after_rst");
    chk("lhu_value", wr_data, 32'h00008001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
